// File: rtl/corr_engine.sv
// Purpose: template-correlation engine; sums frame[(Y+j)*H_RES+X+i] * tpl[j*TPL_W+i] over a TPL_W x TPL_H window.
// Latency: start sampled at cycle 0, one element per cycle in FETCH (1..N), DRAIN at N+1, finished pulse at N+2.
// Backpressure: none; memory/template reads return in exactly 1 cycle, and starts while busy are dropped.
// Ports: iCLK/iRST clock and async active-high reset; iStart/iX/iY request; oMemAddr/oMemRd/iMemData frame read;
//        oTplIdx/iTplData template read; oBusy status; oCorrFinished/oCurrentCorr result.
module corr_engine #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int TPL_W  = 8,
  parameter int TPL_H  = 8,
  parameter int ADDR_W = 19,
  parameter int TIDX_W = 6
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  input  logic [12:0]       iX,
  input  logic [12:0]       iY,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic              oMemRd,
  input  logic [7:0]        iMemData,
  output logic [TIDX_W-1:0] oTplIdx,
  input  logic [7:0]        iTplData,
  output logic              oBusy,
  output logic              oCorrFinished,
  output logic [31:0]       oCurrentCorr
);

  localparam int IW = (TPL_W > 1) ? $clog2(TPL_W) : 1;
  localparam int JW = (TPL_H > 1) ? $clog2(TPL_H + 1) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state, stateNext;
  logic [12:0]       xOrg, yOrg;
  logic [IW-1:0]     colCnt;
  logic [JW-1:0]     rowCnt;
  logic [TIDX_W-1:0] tplIdx;
  logic [13:0]       xPos, yPos;
  logic              inFrame;
  logic              lastElem;
  logic              fetchRd;
  logic              startAccept;
  logic [ADDR_W-1:0] addrCalc, addrHold;
  logic              rdValid;
  logic [15:0]       pixProd;
  logic [31:0]       acc, accNext;

  // 14-bit positions so that an origin near 8191 plus an offset cannot wrap back into the frame.
  assign xPos     = {1'b0, xOrg} + 14'(colCnt);
  assign yPos     = {1'b0, yOrg} + 14'(rowCnt);
  assign inFrame  = (int'(xPos) < H_RES) && (int'(yPos) < V_RES);
  assign addrCalc = ADDR_W'(yPos) * ADDR_W'(H_RES) + ADDR_W'(xPos);
  assign lastElem = (tplIdx == TIDX_W'(TPL_W * TPL_H - 1));

  assign startAccept = (state == IDLE) && iStart;

  // rdValid marks the cycle the returned pixel belongs to an in-frame element.
  assign pixProd = 16'(iMemData) * 16'(iTplData);
  assign accNext = acc + (rdValid ? 32'(pixProd) : 32'd0);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext     = state;
    oBusy         = 1'b1;
    oCorrFinished = 1'b0;
    fetchRd       = 1'b0;
    case (state)
      IDLE: begin
        oBusy = 1'b0;
        if (iStart) stateNext = FETCH;
      end
      FETCH: begin
        fetchRd = inFrame;
        if (lastElem) stateNext = DRAIN;
      end
      DRAIN: stateNext = DONE;
      DONE: begin
        oCorrFinished = 1'b1;
        stateNext     = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Skipped (out-of-frame) elements leave the address bus parked on the last real read.
  assign oMemRd   = fetchRd;
  assign oMemAddr = fetchRd ? addrCalc : addrHold;
  assign oTplIdx  = (state == FETCH) ? tplIdx : '0;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      xOrg         <= '0;
      yOrg         <= '0;
      colCnt       <= '0;
      rowCnt       <= '0;
      tplIdx       <= '0;
      addrHold     <= '0;
      rdValid      <= 1'b0;
      acc          <= '0;
      oCurrentCorr <= '0;
    end else begin
      rdValid <= fetchRd;
      if (fetchRd) addrHold <= addrCalc;

      if (startAccept) begin
        xOrg   <= iX;
        yOrg   <= iY;
        colCnt <= '0;
        rowCnt <= '0;
        tplIdx <= '0;
        acc    <= '0;
      end else begin
        acc <= accNext;
        if (state == FETCH) begin
          tplIdx <= tplIdx + 1'b1;
          if (colCnt == IW'(TPL_W - 1)) begin
            colCnt <= '0;
            rowCnt <= rowCnt + 1'b1;
          end else begin
            colCnt <= colCnt + 1'b1;
          end
        end
        // The last product arrives during DRAIN, so publish the sum including it.
        if (state == DRAIN) oCurrentCorr <= accNext;
      end
    end
  end

endmodule

// File: tb/tb_corr_engine.sv
module tb_corr_engine;

  localparam int H = 640;
  localparam int V = 480;
  localparam int N = 64;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iStart = 1'b0;
  logic [12:0] iX = '0;
  logic [12:0] iY = '0;
  logic [18:0] oMemAddr;
  logic        oMemRd;
  logic [7:0]  iMemData = '0;
  logic [5:0]  oTplIdx;
  logic [7:0]  iTplData = '0;
  logic        oBusy;
  logic        oCorrFinished;
  logic [31:0] oCurrentCorr;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] frame [0:H*V-1];
  logic [7:0] tpl [0:N-1];

  // Reference model results
  int expSum;
  int expAddr[$];
  int prevCorr;

  // Observations from one request
  int obsAddr[$];
  int strobes, idxErr, finCount, finCyc, addrErr;
  logic [31:0] corrAtFin, corrBefore;
  logic busy1, busyLast, busyAfter;

  corr_engine dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iX(iX), .iY(iY),
    .oMemAddr(oMemAddr), .oMemRd(oMemRd), .iMemData(iMemData),
    .oTplIdx(oTplIdx), .iTplData(iTplData), .oBusy(oBusy),
    .oCorrFinished(oCorrFinished), .oCurrentCorr(oCurrentCorr)
  );

  always #10 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  // Frame/template stores with 1-cycle read latency; unread cycles return noise.
  always @(posedge iCLK) begin
    if (oMemRd && (int'(oMemAddr) < H*V)) iMemData <= frame[oMemAddr];
    else iMemData <= 8'($urandom);
    iTplData <= tpl[oTplIdx];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fillConst(input logic [7:0] f, input logic [7:0] t);
    for (int a = 0; a < H*V; a++) frame[a] = f;
    for (int a = 0; a < N; a++) tpl[a] = t;
  endtask

  task automatic fillRandFrame();
    for (int a = 0; a < H*V; a++) frame[a] = 8'($urandom);
  endtask

  task automatic fillRandTpl();
    for (int a = 0; a < N; a++) tpl[a] = 8'($urandom);
  endtask

  // Window sum over in-frame pixels plus the ordered list of addresses that must be read.
  task automatic model(input int x, input int y);
    expSum = 0;
    expAddr.delete();
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++)
        if (x + i < H && y + j < V) begin
          expAddr.push_back((y + j) * H + x + i);
          expSum += int'(frame[(y + j) * H + x + i]) * int'(tpl[j * 8 + i]);
        end
  endtask

  task automatic checkOutputsZero(input string t);
    check({t, " addr0"}, 64'(oMemAddr), 0);
    check({t, " rd0"}, 64'(oMemRd), 0);
    check({t, " idx0"}, 64'(oTplIdx), 0);
    check({t, " busy0"}, 64'(oBusy), 0);
    check({t, " fin0"}, 64'(oCorrFinished), 0);
    check({t, " corr0"}, 64'(oCurrentCorr), 0);
  endtask

  task automatic runReq(input int x, input int y, input int ignAt, input int rstAt);
    int c0, rel;
    obsAddr.delete();
    strobes = 0; idxErr = 0; finCount = 0; finCyc = -1;
    corrAtFin = '0; corrBefore = '0;
    busy1 = 1'b0; busyLast = 1'b0; busyAfter = 1'b1;
    @(negedge iCLK);
    iStart = 1'b1; iX = 13'(x); iY = 13'(y);
    c0 = cyc;
    for (int k = 1; k <= 75; k++) begin
      @(negedge iCLK);
      rel = cyc - c0;
      if (oMemRd) begin
        strobes++;
        obsAddr.push_back(int'(oMemAddr));
      end
      if (rel >= 1 && rel <= N && oTplIdx !== 6'(rel - 1)) idxErr++;
      if (oCorrFinished) begin
        finCount++;
        finCyc = rel;
        corrAtFin = oCurrentCorr;
      end
      if (rel == 1) busy1 = oBusy;
      if (rel == N + 1) corrBefore = oCurrentCorr;
      if (rel == N + 2) busyLast = oBusy;
      if (rel == N + 3) busyAfter = oBusy;
      if (rel == 1) iStart = 1'b0;
      if (rel == ignAt) begin
        iStart = 1'b1; iX = 13'd300; iY = 13'd200;
      end
      if (ignAt > 0 && rel == ignAt + 1) iStart = 1'b0;
      if (rel == rstAt) begin
        iRST = 1'b1;
        #1;
        checkOutputsZero("midreset");
      end
      if (rstAt > 0 && rel == rstAt + 1) iRST = 1'b0;
    end
  endtask

  task automatic checkRun(input string t);
    addrErr = 0;
    for (int i = 0; i < expAddr.size(); i++)
      if (i >= obsAddr.size() || obsAddr[i] != expAddr[i]) addrErr++;
    check({t, " finCyc"}, 64'(finCyc), N + 2);
    check({t, " finCount"}, 64'(finCount), 1);
    check({t, " result"}, 64'(corrAtFin), 64'(expSum));
    check({t, " strobes"}, 64'(strobes), 64'(expAddr.size()));
    check({t, " addrErr"}, 64'(addrErr), 0);
    check({t, " idxErr"}, 64'(idxErr), 0);
    check({t, " busy1"}, 64'(busy1), 1);
    check({t, " busyLast"}, 64'(busyLast), 1);
    check({t, " busyAfter"}, 64'(busyAfter), 0);
    check({t, " corrHeld"}, 64'(corrBefore), 64'(prevCorr));
    prevCorr = expSum;
  endtask

  initial begin
    int rx, ry, firstA, lastA;
    prevCorr = 0;
    fillConst(8'd2, 8'd3);

    iRST = 1'b1;
    repeat (3) @(negedge iCLK);
    checkOutputsZero("reset");
    iRST = 1'b0;
    repeat (2) @(negedge iCLK);

    // Uniform 2 x 3 at origin
    model(0, 0);
    runReq(0, 0, 0, 0);
    checkRun("t1");
    check("t1 const", 64'(corrAtFin), 384);
    check("t1 strobes64", 64'(strobes), 64);

    // Address sequence from (10,5)
    model(10, 5);
    runReq(10, 5, 0, 0);
    checkRun("t2");
    firstA = (obsAddr.size() > 0) ? obsAddr[0] : -1;
    lastA = (obsAddr.size() > 0) ? obsAddr[obsAddr.size() - 1] : -1;
    check("t2 firstAddr", 64'(firstA), 3210);
    check("t2 lastAddr", 64'(lastA), 7697);

    // Right edge clipping
    model(636, 0);
    runReq(636, 0, 0, 0);
    checkRun("t3");
    check("t3 const", 64'(corrAtFin), 192);
    check("t3 strobes32", 64'(strobes), 32);

    // Maximum values, then fully outside origin
    fillConst(8'd255, 8'd255);
    model(100, 100);
    runReq(100, 100, 0, 0);
    checkRun("t4");
    check("t4 const", 64'(corrAtFin), 4161600);
    model(700, 500);
    runReq(700, 500, 0, 0);
    checkRun("t5");
    check("t5 const", 64'(corrAtFin), 0);
    check("t5 strobes0", 64'(strobes), 0);

    // Start while busy is ignored
    fillRandFrame();
    fillRandTpl();
    model(50, 60);
    runReq(50, 60, 20, 0);
    checkRun("t6");

    // Reset mid-request: no pulse, result cleared
    runReq(5, 5, 0, 30);
    check("t7 noPulse", 64'(finCount), 0);
    check("t7 busyAfter", 64'(busyAfter), 0);
    check("t7 corrCleared", 64'(oCurrentCorr), 0);
    prevCorr = 0;
    fillConst(8'd2, 8'd3);
    model(0, 0);
    runReq(0, 0, 0, 0);
    checkRun("t7b");
    check("t7b const", 64'(corrAtFin), 384);

    // Random data and origins around the bottom-right corner
    fillRandFrame();
    for (int r = 0; r < 4; r++) begin
      fillRandTpl();
      rx = $urandom_range(600, 660);
      ry = $urandom_range(460, 485);
      model(rx, ry);
      runReq(rx, ry, 0, 0);
      checkRun("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
